fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer_if.sv | 10 +
 rtl/fetch_sequencer.sv | 117 +++++++++++
 tb/tb_fetch_sequencer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch channel between the sequencer (master) and memory (slave).
interface fetch_sequencer_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, addr, input ack, rdata);
  modport slave  (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_sequencer.sv
// Single-issue fetch/execute sequencer: fetches from imem, hands the word to the datapath,
// then advances or redirects the PC. Fetch timeout raises a sticky fault and halts.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          ACK_TIMEOUT = 15
) (
  input  logic                clk,
  input  logic                rst,
  fetch_sequencer_if.master   imem,
  input  logic                exec_done,
  input  logic                branch_taken,
  input  logic [31:0]         branch_target,
  input  logic                halt_req,
  input  logic                resume,
  output logic [31:0]         pc,
  output logic [31:0]         instr,
  output logic                instr_valid,
  output logic                fault,
  output logic [15:0]         retired,
  output logic [2:0]          state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_EXEC   = 3'd3,
    S_UPDATE = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  // Count of completed no-ack WAIT cycles; reaching LAST on a no-ack cycle is the timeout.
  localparam logic [7:0] LAST = 8'(ACK_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        fault_q;
  logic [15:0] retired_q;
  logic        halt_seen;
  logic [7:0]  cnt;
  logic        br_q;
  logic [31:0] tgt_q;
  logic        timeout;
  logic        halt_now;

  assign timeout  = (state_q == S_WAIT) && !imem.ack && (cnt == LAST);
  assign halt_now = halt_req || halt_seen;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH:  state_d = S_WAIT;
      S_WAIT: begin
        if (imem.ack)    state_d = S_EXEC;
        else if (timeout) state_d = S_HALT;
      end
      S_EXEC:   if (exec_done) state_d = S_UPDATE;
      S_UPDATE: state_d = halt_now ? S_HALT : S_FETCH;
      S_HALT:   if (resume) state_d = S_FETCH;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      fault_q   <= 1'b0;
      retired_q <= '0;
      halt_seen <= 1'b0;
      cnt       <= '0;
      br_q      <= 1'b0;
      tgt_q     <= '0;
    end else begin
      // A halt request anywhere in the fetch/execute window is honoured after retire.
      if ((state_q == S_FETCH || state_q == S_WAIT || state_q == S_EXEC) && halt_req)
        halt_seen <= 1'b1;
      case (state_q)
        S_FETCH: cnt <= '0;
        S_WAIT: begin
          if (imem.ack)     instr_q <= imem.rdata;
          else if (timeout) fault_q <= 1'b1;
          else              cnt     <= cnt + 8'd1;
        end
        S_EXEC: begin
          if (exec_done) begin
            br_q  <= branch_taken;
            tgt_q <= branch_target;
          end
        end
        S_UPDATE: begin
          pc_q      <= br_q ? {tgt_q[31:2], 2'b00} : pc_q + 32'd4;
          retired_q <= retired_q + 16'd1;
        end
        S_HALT: if (resume) halt_seen <= 1'b0;
        default: ;
      endcase
    end
  end

  assign imem.req    = (state_q == S_FETCH) || (state_q == S_WAIT);
  assign imem.addr   = pc_q;
  assign pc          = pc_q;
  assign instr       = instr_q;
  assign instr_valid = (state_q == S_EXEC);
  assign fault       = fault_q;
  assign retired     = retired_q;
  assign state       = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized self-checking bench: a transaction-level PC/retire model predicts every fetch address.
module tb_fetch_sequencer;
  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          TMO    = 15;
  localparam logic [2:0]  S_IDLE = 3'd0, S_FETCH = 3'd1, S_WAIT = 3'd2,
                          S_EXEC = 3'd3, S_UPDATE = 3'd4, S_HALT = 3'd5;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        exec_done = 1'b0, branch_taken = 1'b0, halt_req = 1'b0, resume = 1'b0;
  logic [31:0] branch_target = '0;
  logic [31:0] pc, instr;
  logic        instr_valid, fault;
  logic [15:0] retired;
  logic [2:0]  state;

  fetch_sequencer_if imem();

  fetch_sequencer #(.RESET_PC(RST_PC), .ACK_TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .imem(imem),
    .exec_done(exec_done), .branch_taken(branch_taken), .branch_target(branch_target),
    .halt_req(halt_req), .resume(resume),
    .pc(pc), .instr(instr), .instr_valid(instr_valid), .fault(fault),
    .retired(retired), .state(state)
  );

  always #5 clk = ~clk;

  int          passed = 0;
  int          total  = 0;
  logic [31:0] pc_m;
  int          ret_m;

  // Architectural rule: branch target is word-aligned, otherwise fall through by 4 (mod 2^32).
  function automatic logic [31:0] next_pc(input logic [31:0] cur, input logic br, input logic [31:0] tgt);
    return br ? (tgt & 32'hFFFF_FFFC) : cur + 32'd4;
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; imem.ack = 1'b0; imem.rdata = '0;
    exec_done = 1'b0; branch_taken = 1'b0; halt_req = 1'b0; resume = 1'b0;
    step(); step();
    rst = 1'b0;
    step();
    pc_m = RST_PC; ret_m = 0;
  endtask

  // Drives one full instruction starting from FETCH; exec_lat==0 means exec_done already high on EXEC entry.
  task automatic run_instr(input int ack_lat, input int exec_lat, input logic br, input logic [31:0] tgt,
                           input bit halt_wait, output logic [31:0] addr_seen, output logic req_seen,
                           output logic [31:0] rdata_sent, output logic [31:0] instr_seen,
                           output logic iv_seen, output logic [2:0] end_state, output bit ok);
    int k;
    int need;
    ok = 1; addr_seen = 'x; req_seen = 1'b0; rdata_sent = '0; instr_seen = 'x; iv_seen = 1'b0;
    end_state = state;
    if (state !== S_FETCH) begin ok = 0; return; end
    addr_seen = imem.addr; req_seen = imem.req;
    step();
    k = 1;
    while (1) begin
      if (state !== S_WAIT || k > TMO) begin ok = 0; end_state = state; return; end
      halt_req = halt_wait && (k == 1);
      branch_taken = 1'($urandom); branch_target = $urandom;
      if (k == ack_lat) begin
        imem.ack = 1'b1; imem.rdata = $urandom; rdata_sent = imem.rdata;
        if (exec_lat == 0) begin exec_done = 1'b1; branch_taken = br; branch_target = tgt; end
      end
      step();
      imem.ack = 1'b0; halt_req = 1'b0;
      if (k == ack_lat) break;
      k++;
    end
    need = (exec_lat == 0) ? 1 : exec_lat;
    for (int j = 1; j <= need; j++) begin
      if (state !== S_EXEC) begin ok = 0; end_state = state; exec_done = 1'b0; return; end
      if (j == 1) begin instr_seen = instr; iv_seen = instr_valid && !imem.req; end
      if (j == need) begin exec_done = 1'b1; branch_taken = br; branch_target = tgt; end
      else begin exec_done = 1'b0; branch_taken = 1'($urandom); branch_target = $urandom; end
      step();
    end
    exec_done = 1'b0; branch_taken = 1'b0;
    if (state !== S_UPDATE) ok = 0;
    step();
    end_state = state;
    if (ok) begin pc_m = next_pc(pc_m, br, tgt); ret_m++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(); step();
    total++; if (state !== S_IDLE) $display("FAIL reset_state: got %0d want %0d", state, S_IDLE); else passed++;
    total++; if (pc !== RST_PC) $display("FAIL reset_pc: got %h want %h", pc, RST_PC); else passed++;
    total++; if ({imem.req, instr_valid, fault} !== 3'b000)
      $display("FAIL reset_flags: got %b want 000", {imem.req, instr_valid, fault}); else passed++;
    total++; if (instr !== 32'h0 || retired !== 16'h0)
      $display("FAIL reset_regs: got instr %h retired %0d want 0 0", instr, retired); else passed++;
    rst = 1'b0;
    #1;
    total++; if (state !== S_IDLE) $display("FAIL idle_hold: got %0d want %0d", state, S_IDLE); else passed++;
    step();
    total++; if (state !== S_FETCH) $display("FAIL idle_to_fetch: got %0d want %0d", state, S_FETCH); else passed++;
    pc_m = RST_PC; ret_m = 0;
  endtask

  task automatic test_sequential();
    logic [31:0] a, rd, is; logic rq, iv; logic [2:0] es; bit ok;
    for (int i = 0; i < 3; i++) begin
      run_instr(2, 1, 1'b0, 32'h0, 1'b0, a, rq, rd, is, iv, es, ok);
      total++; if (!ok || es !== S_FETCH) $display("FAIL seq_flow%0d: got ok %0d end %0d want 1 %0d", i, ok, es, S_FETCH); else passed++;
      total++; if (a !== 32'(4 * i) || rq !== 1'b1) $display("FAIL seq_addr%0d: got %h req %b want %h 1", i, a, rq, 32'(4 * i)); else passed++;
      total++; if (is !== rd || iv !== 1'b1) $display("FAIL seq_instr%0d: got %h valid %b want %h 1", i, is, iv, rd); else passed++;
    end
    total++; if (retired !== 16'd3 || pc !== 32'd12) $display("FAIL seq_final: got ret %0d pc %h want 3 0000000c", retired, pc); else passed++;
  endtask

  task automatic test_branch();
    logic [31:0] a, rd, is; logic rq, iv; logic [2:0] es; bit ok; int r0;
    r0 = ret_m;
    run_instr(1, 2, 1'b1, 32'h0000_0103, 1'b0, a, rq, rd, is, iv, es, ok);
    total++; if (!ok || imem.addr !== 32'h0000_0100 || !imem.req)
      $display("FAIL branch_addr: got ok %0d addr %h want 1 00000100", ok, imem.addr); else passed++;
    total++; if (retired !== 16'(r0 + 1)) $display("FAIL branch_retired: got %0d want %0d", retired, r0 + 1); else passed++;
  endtask

  task automatic test_wrap();
    logic [31:0] a, rd, is; logic rq, iv; logic [2:0] es; bit ok;
    run_instr(1, 1, 1'b1, 32'hFFFF_FFFF, 1'b0, a, rq, rd, is, iv, es, ok);
    total++; if (!ok || pc !== 32'hFFFF_FFFC) $display("FAIL wrap_setup: got ok %0d pc %h want 1 fffffffc", ok, pc); else passed++;
    run_instr(2, 1, 1'b0, 32'h0, 1'b0, a, rq, rd, is, iv, es, ok);
    total++; if (!ok || a !== 32'hFFFF_FFFC || pc !== 32'h0)
      $display("FAIL wrap_pc: got ok %0d addr %h pc %h want 1 fffffffc 00000000", ok, a, pc); else passed++;
  endtask

  task automatic test_timeout();
    logic [31:0] a, rd, is, pc0; logic rq, iv; logic [2:0] es; bit ok; bit bad; int r0;
    pc0 = pc; r0 = retired; bad = 0;
    step();
    for (int k = 1; k <= TMO; k++) begin
      if (state !== S_WAIT || fault !== 1'b0) bad = 1;
      step();
    end
    total++; if (bad) $display("FAIL timeout_wait: left WAIT or faulted early, state %0d want %0d", state, S_HALT); else passed++;
    total++; if (state !== S_HALT || fault !== 1'b1) $display("FAIL timeout_fault: got state %0d fault %b want %0d 1", state, fault, S_HALT); else passed++;
    total++; if (pc !== pc0 || retired !== 16'(r0) || imem.req !== 1'b0)
      $display("FAIL timeout_frozen: got pc %h ret %0d req %b want %h %0d 0", pc, retired, imem.req, pc0, r0); else passed++;
    resume = 1'b1; step(); resume = 1'b0;
    total++; if (state !== S_FETCH || fault !== 1'b1) $display("FAIL timeout_resume: got state %0d fault %b want %0d 1", state, fault, S_FETCH); else passed++;
    do_reset();
    run_instr(TMO, 1, 1'b0, 32'h0, 1'b0, a, rq, rd, is, iv, es, ok);
    total++; if (!ok || fault !== 1'b0 || is !== rd || pc !== 32'd4)
      $display("FAIL ack_last_cycle: got ok %0d fault %b pc %h want 1 0 00000004", ok, fault, pc); else passed++;
  endtask

  task automatic test_halt();
    logic [31:0] a, rd, is, pc0; logic rq, iv; logic [2:0] es; bit ok; bit bad;
    pc0 = pc_m; bad = 0;
    run_instr(3, 2, 1'b0, 32'h0, 1'b1, a, rq, rd, is, iv, es, ok);
    total++; if (!ok || es !== S_HALT || pc !== pc0 + 32'd4)
      $display("FAIL halt_after_retire: got ok %0d state %0d pc %h want 1 %0d %h", ok, es, pc, S_HALT, pc0 + 32'd4); else passed++;
    for (int i = 0; i < 5; i++) begin
      if (state !== S_HALT || imem.req !== 1'b0 || instr_valid !== 1'b0 || pc !== pc_m) bad = 1;
      step();
    end
    total++; if (bad) $display("FAIL halt_hold: got state %0d req %b want %0d 0", state, imem.req, S_HALT); else passed++;
    resume = 1'b1; step(); resume = 1'b0;
    total++; if (state !== S_FETCH || imem.addr !== pc_m)
      $display("FAIL halt_resume: got state %0d addr %h want %0d %h", state, imem.addr, S_FETCH, pc_m); else passed++;
    run_instr(1, 1, 1'b0, 32'h0, 1'b0, a, rq, rd, is, iv, es, ok);
    total++; if (!ok || es !== S_FETCH) $display("FAIL halt_cleared: got ok %0d state %0d want 1 %0d", ok, es, S_FETCH); else passed++;
  endtask

  task automatic test_reset_exec();
    bit reached;
    reached = (state === S_FETCH) && (retired !== 16'h0);
    step();
    imem.ack = 1'b1; imem.rdata = $urandom;
    step();
    imem.ack = 1'b0;
    reached = reached && (state === S_EXEC);
    #2 rst = 1'b1;
    #1;
    total++; if (!reached) $display("FAIL rst_exec_setup: got state %0d ret %0d want %0d nonzero", state, retired, S_EXEC); else passed++;
    total++; if (state !== S_IDLE || pc !== RST_PC || retired !== 16'h0 || instr_valid !== 1'b0)
      $display("FAIL rst_exec: got state %0d pc %h ret %0d valid %b want 0 %h 0 0", state, pc, retired, instr_valid, RST_PC); else passed++;
    do_reset();
  endtask

  task automatic test_random();
    logic [31:0] a, rd, is, tgt, exp_a; logic rq, iv, br; logic [2:0] es; bit ok;
    for (int i = 0; i < 30; i++) begin
      br  = ($urandom_range(3) == 0);
      tgt = $urandom;
      exp_a = pc_m;
      run_instr(int'($urandom_range(TMO, 1)), int'($urandom_range(3)), br, tgt, 1'b0, a, rq, rd, is, iv, es, ok);
      total++; if (!ok || es !== S_FETCH || a !== exp_a || rq !== 1'b1 || is !== rd || iv !== 1'b1)
        $display("FAIL rand%0d: got ok %0d end %0d addr %h instr %h want 1 %0d %h %h", i, ok, es, a, is, S_FETCH, exp_a, rd);
      else passed++;
    end
    total++; if (pc !== pc_m || retired !== 16'(ret_m))
      $display("FAIL rand_final: got pc %h ret %0d want %h %0d", pc, retired, pc_m, ret_m); else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", passed, total);
    $fatal(1);
  end

  initial begin
    imem.ack = 1'b0; imem.rdata = '0;
    test_reset();
    test_sequential();
    test_branch();
    test_wrap();
    test_timeout();
    test_halt();
    test_reset_exec();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
